// File: rtl/ads131_spi_pkg.sv
// Shared types and constants for the ADS131A0x SPI frame master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ads131_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_GAP
  } state_e;

  // ADS131A0x command words (upper 16 bits of the first SPI word)
  localparam logic [15:0] CMD_NULL   = 16'h0000;
  localparam logic [15:0] CMD_RESET  = 16'h0011;
  localparam logic [15:0] CMD_UNLOCK = 16'h0655;
  localparam logic [15:0] CMD_WAKEUP = 16'h0033;

  // Default timing at a 50 MHz system clock
  localparam int DEF_CLK_DIV      = 6;
  localparam int DEF_WORD_BITS    = 24;
  localparam int DEF_NUM_WORDS    = 5;
  localparam int DEF_RST_LOW_CYC  = 250000;
  localparam int DEF_RST_WAIT_CYC = 1000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCLK half-period enable: one-cycle tick every CLK_DIV cycles while enabled.
// Latency: first tick CLK_DIV cycles after en_i rises (count starts at 0).
// Backpressure: none; counter is held at zero whenever en_i is low.
module spi_tick_gen #(
  parameter int CLK_DIV = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  // Next count: wrap on tick, hold cleared while disabled
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ads131_spi_frame_master.sv
// ADS131A0x SPI engine: RESET-pin power-up sequence and multi-word mode-1 SPI frames.
// Latency: request to frame_done = 1 + 2*CLK_DIV + 2*CLK_DIV*WORD_BITS*NUM_WORDS cycles.
// Backpressure: none; requests arriving while busy are dropped. Option: ADS131_DRDY_SYNC_EN.
module ads131_spi_frame_master
  import ads131_spi_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int WORD_BITS    = DEF_WORD_BITS,
  parameter int NUM_WORDS    = DEF_NUM_WORDS,
  parameter int RST_LOW_CYC  = DEF_RST_LOW_CYC,
  parameter int RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
  input  logic                                                 system_clock,
  input  logic                                                 reset,
  input  logic                                                 init_req,
  input  logic                                                 xfer_req,
  input  logic [WORD_BITS-1:0]                                 tx_word,
  output logic                                                 tx_load,
  output logic [(NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1)-1:0]   tx_index,
  output logic [WORD_BITS-1:0]                                 rx_word,
  output logic                                                 rx_valid,
  output logic [(NUM_WORDS > 1 ? $clog2(NUM_WORDS) : 1)-1:0]   rx_index,
  output logic                                                 busy,
  output logic                                                 init_done,
  output logic                                                 frame_done,
  output logic                                                 SPI_SCLK,
  output logic                                                 SPI_MOSI,
  input  logic                                                 SPI_MISO,
  output logic                                                 SPI_CS,
`ifdef ADS131_DRDY_SYNC_EN
  input  logic                                                 adc_drdy_n,
`endif
  output logic                                                 SPI_RESET
);

  localparam int IDXW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BITW = $clog2(WORD_BITS);
  localparam int WCW  = $clog2(NUM_WORDS + 1);
  localparam int CYCW = $clog2(max3(RST_LOW_CYC, RST_WAIT_CYC, CLK_DIV) + 1);

  state_e                state_q, state_d;
  logic [CYCW-1:0]       cyc_cnt_q, cyc_cnt_d;
  logic [BITW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [WORD_BITS-1:0]  tx_sr_q, tx_sr_d;
  logic [WORD_BITS-2:0]  rx_sr_q, rx_sr_d;
  logic [WORD_BITS-1:0]  rx_word_q, rx_word_d;
  logic [IDXW-1:0]       rx_index_q, rx_index_d;
  logic [IDXW-1:0]       tx_index_q, tx_index_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_load_q, tx_load_d;
  logic                  frame_done_q, frame_done_d;
  logic                  init_done_q, init_done_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  cs_q, cs_d;
  logic                  rst_n_q, rst_n_d;
  logic                  load_now;
  logic                  start_req;
  logic                  tick;
  logic [WORD_BITS-1:0]  rx_full;

`ifdef ADS131_DRDY_SYNC_EN
  logic [1:0] drdy_sync_q;
  logic       drdy_prev_q;
  logic       drdy_fall_q;

  // Two-flop synchroniser plus registered falling-edge detect (request 3 cycles after pin edge)
  always_ff @(posedge system_clock) begin
    if (reset) begin
      drdy_sync_q <= 2'b11;
      drdy_prev_q <= 1'b1;
      drdy_fall_q <= 1'b0;
    end else begin
      drdy_sync_q <= {drdy_sync_q[0], adc_drdy_n};
      drdy_prev_q <= drdy_sync_q[1];
      drdy_fall_q <= drdy_prev_q & ~drdy_sync_q[1];
    end
  end

  assign start_req = xfer_req | drdy_fall_q;
`else
  assign start_req = xfer_req;
`endif

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (system_clock),
    .rst_i  (reset),
    .en_i   ((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT)),
    .tick_o (tick)
  );

  assign rx_full = {rx_sr_q, SPI_MISO};

  // Next-state and datapath: sequencing of reset pin, CS framing and bit shifting
  always_comb begin
    state_d      = state_q;
    cyc_cnt_d    = cyc_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    tx_sr_d      = tx_sr_q;
    rx_sr_d      = rx_sr_q;
    rx_word_d    = rx_word_q;
    rx_index_d   = rx_index_q;
    tx_index_d   = tx_index_q;
    init_done_d  = init_done_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    cs_d         = cs_q;
    rst_n_d      = rst_n_q;
    rx_valid_d   = 1'b0;
    tx_load_d    = 1'b0;
    frame_done_d = 1'b0;
    load_now     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_req) begin
          state_d     = ST_RST_LOW;
          init_done_d = 1'b0;
          rst_n_d     = 1'b0;
          cyc_cnt_d   = '0;
        end else if (start_req && init_done_q) begin
          // Word 0 is fetched combinationally in the request cycle
          load_now   = 1'b1;
          tx_sr_d    = tx_word;
          tx_index_d = '0;
          cs_d       = 1'b0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          state_d    = ST_CS_SETUP;
        end
      end
      ST_RST_LOW: begin
        if (cyc_cnt_q == CYCW'(RST_LOW_CYC - 1)) begin
          state_d   = ST_RST_WAIT;
          rst_n_d   = 1'b1;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYCW'(1);
        end
      end
      ST_RST_WAIT: begin
        if (cyc_cnt_q == CYCW'(RST_WAIT_CYC - 1)) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
          cyc_cnt_d   = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYCW'(1);
        end
      end
      ST_CS_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
          mosi_d  = tx_sr_q[WORD_BITS-1];
          tx_sr_d = {tx_sr_q[WORD_BITS-2:0], 1'b0};
        end
      end
      ST_SHIFT: begin
        // Next word arrives one cycle after the previous word's last falling edge,
        // always ahead of the following rising edge since CLK_DIV >= 2
        if (tx_load_q) begin
          tx_sr_d = tx_word;
        end
        if (tick) begin
          if (sclk_q) begin
            sclk_d  = 1'b0;
            rx_sr_d = rx_full[WORD_BITS-2:0];
            if (bit_cnt_q == BITW'(WORD_BITS - 1)) begin
              bit_cnt_d  = '0;
              rx_word_d  = rx_full;
              rx_valid_d = 1'b1;
              rx_index_d = word_cnt_q[IDXW-1:0];
              word_cnt_d = word_cnt_q + WCW'(1);
              if (word_cnt_q != WCW'(NUM_WORDS - 1)) begin
                tx_load_d  = 1'b1;
                tx_index_d = IDXW'(word_cnt_q + WCW'(1));
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BITW'(1);
            end
          end else if (word_cnt_q == WCW'(NUM_WORDS)) begin
            // Trailing low half of the last bit has elapsed
            state_d    = ST_CS_HOLD;
            mosi_d     = 1'b0;
            cyc_cnt_d  = '0;
            tx_index_d = '0;
          end else begin
            sclk_d  = 1'b1;
            mosi_d  = tx_sr_q[WORD_BITS-1];
            tx_sr_d = {tx_sr_q[WORD_BITS-2:0], 1'b0};
          end
        end
      end
      ST_CS_HOLD: begin
        if (cyc_cnt_q == CYCW'(CLK_DIV - 1)) begin
          state_d      = ST_CS_GAP;
          cs_d         = 1'b1;
          frame_done_d = 1'b1;
          cyc_cnt_d    = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYCW'(1);
        end
      end
      ST_CS_GAP: begin
        if (cyc_cnt_q == CYCW'(CLK_DIV - 1)) begin
          state_d   = ST_IDLE;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to the safe pin levels
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cyc_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      rx_word_q    <= '0;
      rx_index_q   <= '0;
      tx_index_q   <= '0;
      rx_valid_q   <= 1'b0;
      tx_load_q    <= 1'b0;
      frame_done_q <= 1'b0;
      init_done_q  <= 1'b0;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      cs_q         <= 1'b1;
      rst_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      tx_sr_q      <= tx_sr_d;
      rx_sr_q      <= rx_sr_d;
      rx_word_q    <= rx_word_d;
      rx_index_q   <= rx_index_d;
      tx_index_q   <= tx_index_d;
      rx_valid_q   <= rx_valid_d;
      tx_load_q    <= tx_load_d;
      frame_done_q <= frame_done_d;
      init_done_q  <= init_done_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      cs_q         <= cs_d;
      rst_n_q      <= rst_n_d;
    end
  end

  assign tx_load    = tx_load_q | (load_now & ~reset);
  assign tx_index   = tx_index_q;
  assign rx_word    = rx_word_q;
  assign rx_valid   = rx_valid_q;
  assign rx_index   = rx_index_q;
  assign busy       = (state_q != ST_IDLE);
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
  assign SPI_SCLK   = sclk_q;
  assign SPI_MOSI   = mosi_q;
  assign SPI_CS     = cs_q;
  assign SPI_RESET  = rst_n_q;

endmodule

// File: tb/tb_ads131_spi_frame_master.sv
// Directed bench for ads131_spi_frame_master with a small ADC pin model.
`timescale 1ns/1ps
module tb_ads131_spi_frame_master;

  logic       system_clock = 1'b0;
  logic       reset = 1'b1;
  logic       init_req = 1'b0;
  logic       xfer_req = 1'b0;
  logic [7:0] tx_word;
  logic       tx_load;
  logic [0:0] tx_index;
  logic [7:0] rx_word;
  logic       rx_valid;
  logic [0:0] rx_index;
  logic       busy, init_done, frame_done;
  logic       SPI_SCLK, SPI_MOSI, SPI_CS, SPI_RESET;
  logic       SPI_MISO = 1'b0;
`ifdef ADS131_DRDY_SYNC_EN
  logic       adc_drdy_n = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  always #10 system_clock = ~system_clock;

  // Host returns 8'hA5 for slot 0 and 8'h3C for slot 1
  assign tx_word = (tx_index == 1'b0) ? 8'hA5 : 8'h3C;

  ads131_spi_frame_master #(
    .CLK_DIV(2), .WORD_BITS(8), .NUM_WORDS(2), .RST_LOW_CYC(10), .RST_WAIT_CYC(20)
  ) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .init_req     (init_req),
    .xfer_req     (xfer_req),
    .tx_word      (tx_word),
    .tx_load      (tx_load),
    .tx_index     (tx_index),
    .rx_word      (rx_word),
    .rx_valid     (rx_valid),
    .rx_index     (rx_index),
    .busy         (busy),
    .init_done    (init_done),
    .frame_done   (frame_done),
    .SPI_SCLK     (SPI_SCLK),
    .SPI_MOSI     (SPI_MOSI),
    .SPI_MISO     (SPI_MISO),
    .SPI_CS       (SPI_CS),
`ifdef ADS131_DRDY_SYNC_EN
    .adc_drdy_n   (adc_drdy_n),
`endif
    .SPI_RESET    (SPI_RESET)
  );

  // Pin monitor / ADC model, sampled on the falling system clock edge
  int          mc = 0, rise_cnt = 0, bad_period = 0, last_rise = 0;
  int          fd_cnt = 0, rxv_cnt = 0, txl_cnt = 0, cs_fall_cnt = 0, miso_idx = 0;
  bit          first_rise = 1'b1;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;
  logic [15:0] mosi_log = 16'h0;
  logic [15:0] miso_pat = 16'h5AC3;
  logic [7:0]  rx_word_log [8];
  int          rx_idx_log  [8];

  always @(negedge system_clock) begin
    mc++;
    if (prev_cs && !SPI_CS) begin
      cs_fall_cnt++;
      first_rise = 1'b1;
      miso_idx = 0;
    end
    if (SPI_SCLK && !prev_sclk) begin
      rise_cnt++;
      if (!first_rise && (mc - last_rise) != 4) bad_period++;
      first_rise = 1'b0;
      last_rise = mc;
      mosi_log = {mosi_log[14:0], SPI_MOSI};
      SPI_MISO = miso_pat[15 - miso_idx];
      miso_idx = (miso_idx + 1) % 16;
    end
    if (frame_done) fd_cnt++;
    if (tx_load) txl_cnt++;
    if (rx_valid) begin
      if (rxv_cnt < 8) begin
        rx_word_log[rxv_cnt] = rx_word;
        rx_idx_log[rxv_cnt]  = int'(rx_index);
      end
      rxv_cnt++;
    end
    prev_sclk = SPI_SCLK;
    prev_cs   = SPI_CS;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge system_clock);
    #1;
  endtask

  // Frame checkpoints relative to the xfer_req cycle; exp = {cs,sclk,mosi,busy,tx_load,rx_valid,frame_done}
  typedef struct {
    int         cyc;
    logic       xfer;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int s_cs, s_txl, s_fd, s_rxv, s_rise, s_bad;
    int low_n, low_first, done_cyc, busy_n;
    bit busy_seen;

    vecs[0]  = '{0,  1'b1, 7'b1000100, "f_c0_load"};
    vecs[1]  = '{1,  1'b0, 7'b0001000, "f_c1_cs_low"};
    vecs[2]  = '{2,  1'b0, 7'b0001000, "f_c2_setup"};
    vecs[3]  = '{3,  1'b0, 7'b0111000, "f_c3_rise_b7"};
    vecs[4]  = '{5,  1'b0, 7'b0011000, "f_c5_fall"};
    vecs[5]  = '{7,  1'b0, 7'b0101000, "f_c7_rise_b6"};
    vecs[6]  = '{33, 1'b0, 7'b0011110, "f_c33_word0"};
    vecs[7]  = '{35, 1'b0, 7'b0101000, "f_c35_rise_w1"};
    vecs[8]  = '{65, 1'b0, 7'b0001010, "f_c65_word1"};
    vecs[9]  = '{67, 1'b0, 7'b0001000, "f_c67_hold"};
    vecs[10] = '{68, 1'b0, 7'b0001000, "f_c68_hold"};
    vecs[11] = '{69, 1'b0, 7'b1001001, "f_c69_done"};
    vecs[12] = '{70, 1'b0, 7'b1001000, "f_c70_gap"};
    vecs[13] = '{71, 1'b0, 7'b1000000, "f_c71_idle"};

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst_pins", {SPI_CS, SPI_SCLK, SPI_MOSI, SPI_RESET, init_done, busy, tx_load, rx_valid, frame_done},
          9'b1_0_0_1_0_0_0_0_0);
    check("rst_data", {rx_word, rx_index, tx_index}, 10'h0);
    reset = 1'b0;
    step();

    // Transfer request before init is ignored
    s_cs = cs_fall_cnt; s_txl = txl_cnt; busy_seen = 1'b0;
    xfer_req = 1'b1;
    step();
    xfer_req = 1'b0;
    repeat (10) begin
      if (busy) busy_seen = 1'b1;
      step();
    end
    check("gate_cs", cs_fall_cnt - s_cs, 0);
    check("gate_txload", txl_cnt - s_txl, 0);
    check("gate_busy", busy_seen, 0);

    // Reset sequence
    low_n = 0; low_first = -1; done_cyc = -1; busy_n = 0;
    for (int c = 0; c < 34; c++) begin
      init_req = (c == 0);
      #1;
      if (!SPI_RESET) begin
        low_n++;
        if (low_first < 0) low_first = c;
      end
      if (init_done && done_cyc < 0) done_cyc = c;
      if (busy) busy_n++;
      step();
    end
    init_req = 1'b0;
    check("init_low_len", low_n, 10);
    check("init_low_start", low_first, 1);
    check("init_done_cyc", done_cyc, 31);
    check("init_busy_len", busy_n, 30);

    // init_req and xfer_req together: only the reset sequence runs
    s_cs = cs_fall_cnt; s_txl = txl_cnt; low_n = 0;
    for (int c = 0; c < 34; c++) begin
      init_req = (c == 0);
      xfer_req = (c == 0);
      #1;
      if (!SPI_RESET) low_n++;
      step();
    end
    init_req = 1'b0; xfer_req = 1'b0;
    check("both_cs", cs_fall_cnt - s_cs, 0);
    check("both_txload", txl_cnt - s_txl, 0);
    check("both_low_len", low_n, 10);
    check("both_init_done", init_done, 1);

    // Table-driven frame
    s_cs = cs_fall_cnt; s_fd = fd_cnt; s_rxv = rxv_cnt; s_rise = rise_cnt; s_bad = bad_period;
    for (int c = 0; c < 73; c++) begin
      xfer_req = 1'b0;
      foreach (vecs[i]) if (vecs[i].cyc == c) xfer_req = vecs[i].xfer;
      #1;
      foreach (vecs[i]) begin
        if (vecs[i].cyc == c)
          check(vecs[i].name, {SPI_CS, SPI_SCLK, SPI_MOSI, busy, tx_load, rx_valid, frame_done}, vecs[i].exp);
      end
      if (c == 33) check("f_tx_index1", tx_index, 1);
      step();
    end
    xfer_req = 1'b0;
    check("f_rx_count", rxv_cnt - s_rxv, 2);
    check("f_rx0_idx", rx_idx_log[s_rxv], 0);
    check("f_rx0_word", rx_word_log[s_rxv], 8'h5A);
    check("f_rx1_idx", rx_idx_log[s_rxv + 1], 1);
    check("f_rx1_word", rx_word_log[s_rxv + 1], 8'hC3);
    check("f_mosi_stream", mosi_log, 16'hA53C);
    check("f_sclk_periods", rise_cnt - s_rise, 16);
    check("f_sclk_gap", bad_period - s_bad, 0);
    check("f_done_count", fd_cnt - s_fd, 1);
    check("f_cs_count", cs_fall_cnt - s_cs, 1);

    // Second request during a frame is dropped
    s_cs = cs_fall_cnt; s_fd = fd_cnt; s_rxv = rxv_cnt;
    for (int c = 0; c < 150; c++) begin
      xfer_req = (c == 0) || (c == 20);
      step();
    end
    xfer_req = 1'b0;
    check("drop_done", fd_cnt - s_fd, 1);
    check("drop_cs", cs_fall_cnt - s_cs, 1);
    check("drop_rx", rxv_cnt - s_rxv, 2);

`ifdef ADS131_DRDY_SYNC_EN
    // DRDY falling edge starts a frame; a second edge while busy is ignored
    begin
      int first_txl, first_cs;
      first_txl = -1; first_cs = -1;
      s_fd = fd_cnt;
      for (int c = 0; c < 150; c++) begin
        if (c == 0)  adc_drdy_n = 1'b0;
        if (c == 10) adc_drdy_n = 1'b1;
        if (c == 20) adc_drdy_n = 1'b0;
        #1;
        if (tx_load && first_txl < 0) first_txl = c;
        if (!SPI_CS && first_cs < 0) first_cs = c;
        step();
      end
      adc_drdy_n = 1'b1;
      repeat (5) step();
      check("drdy_txload_cyc", first_txl, 3);
      check("drdy_cs_cyc", first_cs, 4);
      check("drdy_frames", fd_cnt - s_fd, 1);
    end
`endif

    // Reset during bit 5 of word 0 aborts without completion strobes
    s_cs = cs_fall_cnt; s_fd = fd_cnt; s_rxv = rxv_cnt;
    for (int c = 0; c < 80; c++) begin
      xfer_req = (c == 0);
      reset = (c == 24) || (c == 25);
      #1;
      if (c == 24) check("mid_bit5_sclk", SPI_SCLK, 1);
      if (c == 25) check("mid_abort_pins", {SPI_CS, SPI_SCLK, SPI_MOSI, busy, init_done, tx_load}, 6'b100000);
      step();
    end
    reset = 1'b0; xfer_req = 1'b0;
    check("mid_no_done", fd_cnt - s_fd, 0);
    check("mid_no_rx", rxv_cnt - s_rxv, 0);
    check("mid_one_cs", cs_fall_cnt - s_cs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
